// File: rtl/three_way_toom_cook_seq.sv
// three_way_toom_cook_seq
//   Handshaked carry-less (GF(2)[x]) multiplier. Each N-bit operand is split
//   into three K-bit limbs. Nine digit-serial shift-and-XOR accumulators form
//   the limb products in parallel. The five 3-way coefficients are recombined
//   into a 2N-bit product, which then passes through PIPE output stages.
//
//   Ports
//     clk    rising-edge clock
//     rst    synchronous active-high reset; aborts any in-flight operation
//     start  request, sampled only while idle
//     a, b   N-bit operands, captured on the accepted start
//     busy   high while an operation is in flight
//     done   one-cycle pulse, c valid in this cycle
//     c      2N-bit product, held until the next done
//
//   state | meaning
//   IDLE  | waiting for start; c holds the last result
//   RUN   | R digit-serial accumulation cycles
//   COMB  | recombine coefficients into stage 0
//   DRAIN | shift through PIPE output stages, last stage is c
module three_way_toom_cook_seq #(
    parameter int N     = 224,
    parameter int DIGIT = 1,
    parameter int PIPE  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   c
);

    localparam int K  = (N + 2) / 3;
    localparam int R  = (K + DIGIT - 1) / DIGIT;
    localparam int AW = 2 * K - 1;
    localparam int EW = 3 * K;
    localparam int PW = 2 * N;
    localparam int CW = (R < 2) ? 1 : $clog2(R);
    localparam int DW = (PIPE < 2) ? 1 : $clog2(PIPE);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_COMB, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   drn_q, drn_d;
    logic [N-1:0]    a_q, a_d, b_q, b_d;
    logic [AW-1:0]   acc_q [9];
    logic [AW-1:0]   acc_d [9];
    // pipe_q[0] is the recombine register; pipe_q[PIPE] is the output c.
    logic [PW-1:0]   pipe_q [PIPE+1];
    logic [PW-1:0]   pipe_d [PIPE+1];
    logic            done_q, done_d;

    logic [EW-1:0]   a_ext, b_ext;
    logic [K-1:0]    a_limb [3];
    logic [K-1:0]    b_limb [3];
    logic [AW-1:0]   coef_h, coef_g, coef_f, coef_e, coef_d;
    logic [PW-1:0]   comb_v;

    // Shift-based bit pick: indices at or beyond K read as zero, which also
    // covers the unused tail of a partial last digit.
    function automatic logic bit_at(input logic [K-1:0] v, input int k);
        logic [K-1:0] s;
        s = v >> k;
        return s[0];
    endfunction

    always_comb begin
        a_ext = EW'(a_q);
        b_ext = EW'(b_q);
        for (int i = 0; i < 3; i++) begin
            a_limb[i] = a_ext[i*K +: K];
            b_limb[i] = b_ext[i*K +: K];
        end
        // acc index is 3*i + j for limb product a_i * b_j.
        coef_h = acc_q[0];
        coef_g = acc_q[1] ^ acc_q[3];
        coef_f = acc_q[2] ^ acc_q[4] ^ acc_q[6];
        coef_e = acc_q[5] ^ acc_q[7];
        coef_d = acc_q[8];
        comb_v = PW'(coef_h)
               ^ (PW'(coef_g) << K)
               ^ (PW'(coef_f) << (2 * K))
               ^ (PW'(coef_e) << (3 * K))
               ^ (PW'(coef_d) << (4 * K));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drn_d   = drn_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        pipe_d  = pipe_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d   = a;
                    b_d   = b;
                    cnt_d = '0;
                    for (int m = 0; m < 9; m++) acc_d[m] = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < 3; i++) begin
                    for (int jj = 0; jj < 3; jj++) begin
                        for (int j = 0; j < DIGIT; j++) begin
                            if ((int'(cnt_q) * DIGIT + j) < K &&
                                bit_at(a_limb[i], int'(cnt_q) * DIGIT + j)) begin
                                acc_d[i*3+jj] = acc_d[i*3+jj] ^
                                    (AW'(b_limb[jj]) << (int'(cnt_q) * DIGIT + j));
                            end
                        end
                    end
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(R - 1)) state_d = S_COMB;
            end
            S_COMB: begin
                pipe_d[0] = comb_v;
                if (PIPE == 0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    drn_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The output stage only loads on the final drain cycle so c
                // keeps the previous result until done.
                for (int i = 1; i <= PIPE; i++) begin
                    if (i < PIPE || drn_q == DW'(PIPE - 1)) pipe_d[i] = pipe_q[i-1];
                end
                drn_d = drn_q + 1'b1;
                if (drn_q == DW'(PIPE - 1)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            drn_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            done_q  <= 1'b0;
            for (int m = 0; m < 9; m++) acc_q[m] <= '0;
            for (int i = 0; i <= PIPE; i++) pipe_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drn_q   <= drn_d;
            a_q     <= a_d;
            b_q     <= b_d;
            done_q  <= done_d;
            acc_q   <= acc_d;
            pipe_q  <= pipe_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign c    = pipe_q[PIPE];

endmodule

// File: tb/tb_three_way_toom_cook_seq.sv
// tb_three_way_toom_cook_seq
//   Self-checking bench: a default-parameter instance (N=224, DIGIT=1,
//   PIPE=4) plus two N=8 instances (DIGIT=2/PIPE=2 and DIGIT=3/PIPE=0).
//   Results are compared against a plain bit-by-bit carry-less multiply.
module tb_three_way_toom_cook_seq;

    localparam int N     = 224;
    localparam int DIGIT = 1;
    localparam int PIPE  = 4;
    localparam int K     = (N + 2) / 3;
    localparam int R     = (K + DIGIT - 1) / DIGIT;
    localparam int LAT   = R + 1 + PIPE;
    localparam int LAT1  = (3 + 2 - 1) / 2 + 1 + 2;
    localparam int LAT2  = (3 + 3 - 1) / 3 + 1 + 0;

    logic             clk = 1'b0;
    logic             rst, start;
    logic [N-1:0]     a, b;
    logic             busy, done;
    logic [2*N-1:0]   c;

    logic             s_start;
    logic [7:0]       sa, sb;
    logic             s1_busy, s1_done, s2_busy, s2_done;
    logic [15:0]      s1_c, s2_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    three_way_toom_cook_seq #(.N(N), .DIGIT(DIGIT), .PIPE(PIPE)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .c(c));

    three_way_toom_cook_seq #(.N(8), .DIGIT(2), .PIPE(2)) u_s1 (
        .clk(clk), .rst(rst), .start(s_start), .a(sa), .b(sb),
        .busy(s1_busy), .done(s1_done), .c(s1_c));

    three_way_toom_cook_seq #(.N(8), .DIGIT(3), .PIPE(0)) u_s2 (
        .clk(clk), .rst(rst), .start(s_start), .a(sa), .b(sb),
        .busy(s2_busy), .done(s2_done), .c(s2_c));

    function automatic logic [447:0] clmul(input logic [223:0] x, input logic [223:0] y);
        logic [447:0] r;
        r = '0;
        for (int i = 0; i < 224; i++)
            if (x[i]) r = r ^ ({224'b0, y} << i);
        return r;
    endfunction

    function automatic logic [223:0] rand224();
        logic [223:0] r;
        for (int i = 0; i < 7; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [447:0] obs, input logic [447:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one operation and waits for done. With hold=1 start stays high
    // throughout, so it is re-asserted while busy and still high at done.
    task automatic run_main(input logic [223:0] x, input logic [223:0] y, input bit hold,
                            output int lat, output int busy_n, output logic [447:0] res);
        a = x;
        b = y;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        a = rand224();
        b = rand224();
        lat = 0;
        busy_n = 0;
        while (!done && lat < 300) begin
            if (busy) busy_n++;
            tick();
            lat++;
        end
        res = c;
    endtask

    task automatic run_small(input logic [7:0] x, input logic [7:0] y);
        int n, l1, l2;
        logic [447:0] r1, r2, exp;
        sa = x;
        sb = y;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        sa = 8'($urandom);
        sb = 8'($urandom);
        n = 0; l1 = -1; l2 = -1; r1 = '0; r2 = '0;
        while ((l1 < 0 || l2 < 0) && n < 20) begin
            if (s1_done && l1 < 0) begin l1 = n; r1 = {432'b0, s1_c}; end
            if (s2_done && l2 < 0) begin l2 = n; r2 = {432'b0, s2_c}; end
            tick();
            n++;
        end
        exp = clmul({216'b0, x}, {216'b0, y});
        check("s1_lat", 448'(l1), 448'(LAT1));
        check("s2_lat", 448'(l2), 448'(LAT2));
        check("s1_c", r1, exp);
        check("s2_c", r2, exp);
    endtask

    initial begin
        int lat, bn, dn;
        logic [223:0] x, y, ones;
        logic [447:0] res;

        ones = '1;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        s_start = 1'b0; sa = '0; sb = '0;
        repeat (3) tick();
        check("rst_c", c, '0);
        check("rst_done", 448'(done), '0);
        check("rst_busy", 448'(busy), '0);
        check("rst_s1_c", {432'b0, s1_c}, '0);
        rst = 1'b0;
        tick();

        run_main(224'd1, 224'd1, 1'b0, lat, bn, res);
        check("one_lat", 448'(lat), 448'(LAT));
        check("one_busy_cycles", 448'(bn), 448'(LAT));
        check("one_busy_at_done", 448'(busy), '0);
        check("one_c", res, 448'd1);

        run_main(224'd3, 224'd3, 1'b0, lat, bn, res);
        check("three_c", res, 448'd5);
        check("three_lat", 448'(lat), 448'(LAT));

        x = 224'd1 << 223;
        run_main(x, x, 1'b0, lat, bn, res);
        check("top_c", res, 448'd1 << 446);

        y = 224'd1 << 75;
        run_main(ones, y, 1'b0, lat, bn, res);
        check("limb_edge_c", res, {224'b0, ones} << 75);

        run_main(ones, ones, 1'b0, lat, bn, res);
        check("ones_c", res, clmul(ones, ones));

        for (int i = 0; i < 220; i++) begin
            x = rand224();
            y = rand224();
            if (i % 4 == 1) x = x & ({224'b0} | (224'd1 << $urandom_range(223)));
            run_main(x, y, 1'b0, lat, bn, res);
            check("rand_c", res, clmul(x, y));
            check("rand_lat", 448'(lat), 448'(LAT));
        end

        x = rand224(); y = rand224();
        run_main(x, y, 1'b1, lat, bn, res);
        check("hold1_c", res, clmul(x, y));
        check("hold1_lat", 448'(lat), 448'(LAT));
        x = rand224(); y = rand224();
        run_main(x, y, 1'b1, lat, bn, res);
        check("b2b_c", res, clmul(x, y));
        check("b2b_lat", 448'(lat), 448'(LAT));
        start = 1'b0;
        dn = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done) dn++;
        end
        check("no_queued_done", 448'(dn), '0);
        check("idle_after_hold", 448'(busy), '0);
        check("c_held", c, clmul(x, y));

        x = rand224(); y = rand224();
        a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();
        check("mid_run_busy", 448'(busy), 448'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_c", c, '0);
        check("abort_done", 448'(done), '0);
        check("abort_busy", 448'(busy), '0);
        dn = 0;
        for (int i = 0; i < 90; i++) begin
            tick();
            if (done) dn++;
        end
        check("abort_no_done", 448'(dn), '0);
        x = rand224(); y = rand224();
        run_main(x, y, 1'b0, lat, bn, res);
        check("post_abort_c", res, clmul(x, y));
        check("post_abort_lat", 448'(lat), 448'(LAT));

        run_small(8'h00, 8'h00);
        run_small(8'hFF, 8'hFF);
        run_small(8'h01, 8'hFF);
        run_small(8'h80, 8'h80);
        run_small(8'h07, 8'h38);
        for (int i = 0; i < 1500; i++) run_small(8'($urandom), 8'($urandom));
        check("small_idle", {446'b0, s1_busy, s2_busy}, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
